// File: rtl/project_mux_ctrl.sv
// project_mux_ctrl: owner-select controller for a shared user IO pad mux.
//
// A Wishbone classic slave exposes two registers:
//   BASE_ADDR + 0x00  CTRL   [SELW-1:0] requested project select (req)
//   BASE_ADDR + 0x04  STATUS [SELW-1:0] sel_o, [8] busy_o, [9] sticky ERR (write 1 to clear)
// A legal CTRL write that differs from sel_o runs the switch sequence
// ASSERT -> HOLD (HOLD_CYCLES clocks) -> SWITCH -> RELEASE. The outgoing project is
// held in reset and the pads are tri-stated for the whole sequence. Every project
// that does not own the mux is always held in reset.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_*                     Wishbone classic slave (only byte lane 0 honoured for CTRL)
//   sel_o, sel_valid_o        current owner index and pad-drive enable
//   proj_rst_o                per-project active-high reset
//   busy_o                    a switch sequence is in progress
//   la_sel_i, la_force_i      logic-analyser override, present only with PMC_LA_OVERRIDE_EN
//
// Build option: define PMC_LA_OVERRIDE_EN to add the logic-analyser override; a rising
// edge of la_force_i in IDLE starts a switch to la_sel_i, and CTRL writes are rejected
// while la_force_i is held.
module project_mux_ctrl #(
    parameter int unsigned NPROJ       = 4,
    parameter int unsigned SELW        = 2,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [SELW-1:0]  sel_o,
    output logic             sel_valid_o,
    output logic [NPROJ-1:0] proj_rst_o,
    output logic             busy_o
`ifdef PMC_LA_OVERRIDE_EN
    ,
    input  logic [SELW-1:0]  la_sel_i,
    input  logic             la_force_i
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StHold,
        StSwitch,
        StRelease
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  req_q, req_d;
    logic             sel_valid_q, sel_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic [NPROJ-1:0] proj_rst_q, proj_rst_d;

    logic       wb_req, hit_ctrl, hit_status, ctrl_wr, status_wr;
    logic       sw_valid, err_set;
    logic [7:0] sw_val;

    // Bits that no register field uses.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:10], wbs_dat_i[8]};

    assign wb_req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign hit_ctrl   = (wbs_adr_i == BASE_ADDR);
    assign hit_status = (wbs_adr_i == BASE_ADDR + 32'd4);
    assign ctrl_wr    = wb_req & wbs_we_i & hit_ctrl & wbs_sel_i[0];
    assign status_wr  = wb_req & wbs_we_i & hit_status;

`ifdef PMC_LA_OVERRIDE_EN
    logic la_force_q;
    logic la_rise;
    assign la_rise = la_force_i & ~la_force_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        req_d       = req_q;
        sel_valid_d = sel_valid_q;
        busy_d      = busy_q;
        err_d       = err_q;
        proj_rst_d  = proj_rst_q;
        ack_d       = wb_req;
        dat_d       = '0;
        sw_valid    = 1'b0;
        sw_val      = 8'h00;
        err_set     = 1'b0;

        // Read data is only non-zero in the ack cycle of a mapped read.
        if (wb_req && !wbs_we_i) begin
            if (hit_ctrl) begin
                dat_d[SELW-1:0] = req_q;
            end else if (hit_status) begin
                dat_d[SELW-1:0] = sel_q;
                dat_d[8]        = busy_q;
                dat_d[9]        = err_q;
            end
        end

        unique case (state_q)
            StIdle: ;
            StAssert: begin
                proj_rst_d[sel_q] = 1'b1;
                sel_valid_d       = 1'b0;
                busy_d            = 1'b1;
                cnt_d             = 8'(HOLD_CYCLES - 1);
                state_d           = StHold;
            end
            StHold: begin
                if (cnt_q == 8'd0) begin
                    state_d = StSwitch;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSwitch: begin
                sel_d   = req_q;
                state_d = StRelease;
            end
            StRelease: begin
                proj_rst_d[sel_q] = 1'b0;
                sel_valid_d       = 1'b1;
                busy_d            = 1'b0;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef PMC_LA_OVERRIDE_EN
        if (la_force_i) begin
            err_set  = ctrl_wr;
            sw_valid = la_rise;
            sw_val   = 8'(la_sel_i);
        end else begin
            sw_valid = ctrl_wr;
            sw_val   = wbs_dat_i[7:0];
        end
`else
        sw_valid = ctrl_wr;
        sw_val   = wbs_dat_i[7:0];
`endif

        // Any non-IDLE state counts as busy, so a request landing in RELEASE is rejected.
        if (sw_valid) begin
            if ((sw_val >= 8'(NPROJ)) || (state_q != StIdle)) begin
                err_set = 1'b1;
            end else begin
                req_d = sw_val[SELW-1:0];
                if (sw_val[SELW-1:0] != sel_q) begin
                    state_d = StAssert;
                end
            end
        end

        if (status_wr && wbs_dat_i[9]) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // Reset lands in HOLD so project 0 is released without any bus traffic.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= StHold;
            cnt_q       <= 8'(HOLD_CYCLES - 1);
            sel_q       <= '0;
            req_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            proj_rst_q  <= '1;
`ifdef PMC_LA_OVERRIDE_EN
            la_force_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            req_q       <= req_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            proj_rst_q  <= proj_rst_d;
`ifdef PMC_LA_OVERRIDE_EN
            la_force_q  <= la_force_i;
`endif
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign sel_o       = sel_q;
    assign sel_valid_o = sel_valid_q;
    assign proj_rst_o  = proj_rst_q;
    assign busy_o      = busy_q;

endmodule
